load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  - Initiator side of the data-memory port. Takes one load/store from the MEM stage and drives
//    the byte-addressed data memory (word-aligned address, 4-bit byte strobes, combinational read).
//  - Aligns store data into byte lanes, extracts and sign/zero-extends load data, range-checks,
//    and optionally splits word-crossing accesses into two aligned word accesses.
//  - Sits between the pipeline MEM stage and the data memory; one request in flight.
// PARAMETERS
//  - XLEN       32    data/address width (only 32 supported)
//  - MEM_BYTES  1024  memory size in bytes; any access touching a byte >= MEM_BYTES faults
// PORTS
//  - clk            in   1     clock
//  - reset          in   1     asynchronous, active-high
//  - req_valid      in   1     request present
//  - req_ready      out  1     LSU idle, can accept
//  - req_addr       in   32    byte address
//  - req_wdata      in   32    store data, right-justified
//  - req_store      in   1     1=store, 0=load
//  - req_size       in   2     00 byte, 01 half, 10 word, 11 illegal
//  - req_unsigned   in   1     zero-extend loads (LBU/LHU)
//  - rsp_valid      out  1     one-cycle completion pulse
//  - rsp_rdata      out  32    extended load data (0 for stores and faults)
//  - rsp_fault      out  1     request not performed
//  - rsp_cause      out  2     01 misaligned, 10 out of range, 11 illegal size, 00 none
//  - mem_addr       out  32    word-aligned address (addr[1:0]=0)
//  - mem_wdata      out  32    lane-aligned store data
//  - mem_wr_en      out  4     byte strobes, bit k = byte lane k
//  - mem_read       out  1     read enable
//  - mem_load_type  out  2     constant 2'b10 (word read; extraction done here)
//  - mem_rdata      in   32    combinational read data, valid same cycle as mem_addr
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 after release; rsp_valid=0, rsp_rdata=0, rsp_fault=0,
//    rsp_cause=0; mem_addr=0, mem_wdata=0, mem_wr_en=0, mem_read=0. Takes effect immediately.
//  - FSM IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE. req_ready=1 only in IDLE. Accept = req_valid & req_ready.
//  - nbytes=1/2/4; off=addr[1:0]; cross = off+nbytes>4. Fault checks at accept, priority:
//    illegal size(11) > range (addr+nbytes-1 >= MEM_BYTES, 33-bit sum) > misaligned.
//  - Fault -> RESP directly (rsp at T+1, T = accept edge); no mem strobes/reads ever issued.
//  - ACC0: mem_addr=addr&~3; lanes = low nibble of (((1<<nbytes)-1)<<off) over 8 bits;
//    mem_wdata = low 32 of ({32'b0,wdata}<<8*off). Store: mem_wr_en=lanes. Load: mem_read=1,
//    capture mem_rdata into word0 at clock edge.
//  - ACC1 (only if cross and split enabled): mem_addr=(addr&~3)+4; high nibble/high 32 bits;
//    load captures word1.
//  - RESP: rsp_valid=1 one cycle; load data = ({word1,word0}>>8*off), truncated to nbytes,
//    sign-extended unless req_unsigned. All rsp_* registered, held until next RESP.
//  - Latency: non-crossing T+2; crossing split T+3; fault T+1. No back-to-back accept during RESP.
//  - mem_* outputs are 0 outside ACC0/ACC1 (decoded from registered state, glitch-free strobes).
//  - Reset mid-operation: state IDLE immediately, mem_wr_en drops, pending access/response dropped;
//    a split store interrupted after ACC0 leaves first word written (no rollback).
// CONFIGURATION
//  - LSU_MISALIGN_SPLIT_EN defined: word-crossing accesses (e.g. LW @0x12, LH @0x13) perform
//    ACC0+ACC1, no fault. Non-crossing unaligned (LH @0x11) always single access.
//  - Undefined: any cross -> fault, rsp_cause=01, no memory access, rsp at T+1.
//    Non-crossing unaligned (LH @0x11) still performed in one access.
// TESTING
//  - SW addr 0x10 wdata 0xDEADBEEF -> ACC0: mem_addr 0x10, wr_en 1111, wdata 0xDEADBEEF; rsp T+2 fault 0.
//  - mem[0x10]=0x80FF1234; LB 0x13 -> rdata 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x10 -> 0x00001234.
//  - SH 0x0000ABCD @0x13 (split on) -> ACC0 0x10 wr_en 1000 wdata 0xCD000000; ACC1 0x14 wr_en 0001
//    wdata 0x000000AB; rsp T+3. Split off -> no strobes, rsp T+1 fault cause 01.
//  - mem[0x10]=0x44332211, mem[0x14]=0x88776655; LW 0x12 (split on) -> rdata 0x66554433.
//  - LW @MEM_BYTES-2 -> fault cause 10; size 11 @0x0 -> cause 11; neither touches memory.
//  - Assert reset during ACC0 of SW -> mem_wr_en 0 same cycle, memory unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory initiator: lane alignment, load extension, fault checks, one request in flight.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two aligned word accesses.
module load_store_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic            req_store_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_fault_o,
    output logic [1:0]      rsp_cause_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_wr_en_o,
    output logic            mem_read_o,
    output logic [1:0]      mem_load_type_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    state_e      state_q, state_d;
    logic [29:0] waddr_q;
    logic [1:0]  off_q, size_q, cause_q;
    logic        store_q, unsigned_q, cross_q;
    logic [31:0] wdata_q, word0_q, word1_q;
    logic        rsp_valid_q, rsp_valid_d, rsp_fault_q, rsp_fault_d;
    logic [1:0]  rsp_cause_q, rsp_cause_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic [3:0]  req_nbytes;
    logic        req_cross;
    logic [32:0] req_last;
    logic [1:0]  req_cause;
    logic [63:0] wide;
    logic [7:0]  lanes;
    logic [3:0]  size_mask;
    logic [31:0] ext_src, ext_data;

    // Request decode and fault classification, evaluated in IDLE only.
    always_comb begin
        unique case (req_size_i)
            2'b00:   req_nbytes = 4'd1;
            2'b01:   req_nbytes = 4'd2;
            2'b10:   req_nbytes = 4'd4;
            default: req_nbytes = 4'd0;
        endcase
        req_cross = ({2'b00, req_addr_i[1:0]} + req_nbytes) > 4'd4;
        req_last  = {1'b0, req_addr_i} + {29'd0, req_nbytes} - 33'd1;
        if (req_size_i == 2'b11) begin
            req_cause = 2'b11;
        end else if (req_last >= 33'(MEM_BYTES)) begin
            req_cause = 2'b10;
        end else if (req_cross && !SplitEn) begin
            req_cause = 2'b01;
        end else begin
            req_cause = 2'b00;
        end
    end

    assign accept      = req_valid_i && (state_q == StIdle);
    assign req_ready_o = (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = (req_cause != 2'b00) ? StResp : StAcc0;
            StAcc0: state_d = cross_q ? StAcc1 : StResp;
            StAcc1: state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Load extraction from the (possibly two-word) capture window.
    always_comb begin
        ext_src = 32'({word1_q, word0_q} >> {off_q, 3'b000});
        unique case (size_q)
            2'b00:   ext_data = unsigned_q ? {24'd0, ext_src[7:0]}
                                           : {{24{ext_src[7]}}, ext_src[7:0]};
            2'b01:   ext_data = unsigned_q ? {16'd0, ext_src[15:0]}
                                           : {{16{ext_src[15]}}, ext_src[15:0]};
            default: ext_data = ext_src;
        endcase
    end

    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_fault_d = rsp_fault_q;
        rsp_cause_d = rsp_cause_q;
        rsp_rdata_d = rsp_rdata_q;
        if (state_q == StResp) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = (cause_q != 2'b00);
            rsp_cause_d = cause_q;
            rsp_rdata_d = (store_q || cause_q != 2'b00) ? 32'd0 : ext_data;
        end
    end

    // Memory side decoded from registered state only, so strobes never glitch.
    always_comb begin
        unique case (size_q)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lanes           = {4'd0, size_mask} << off_q;
        wide            = {32'd0, wdata_q} << {off_q, 3'b000};
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        mem_wr_en_o     = 4'b0000;
        mem_read_o      = 1'b0;
        mem_load_type_o = 2'b10;
        if (state_q == StAcc0) begin
            mem_addr_o = {waddr_q, 2'b00};
            if (store_q) begin
                mem_wr_en_o = lanes[3:0];
                mem_wdata_o = wide[31:0];
            end else begin
                mem_read_o = 1'b1;
            end
        end else if (state_q == StAcc1) begin
            mem_addr_o = {waddr_q + 30'd1, 2'b00};
            if (store_q) begin
                mem_wr_en_o = lanes[7:4];
                mem_wdata_o = wide[63:32];
            end else begin
                mem_read_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            waddr_q     <= '0;
            off_q       <= '0;
            size_q      <= '0;
            cause_q     <= '0;
            store_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            cross_q     <= 1'b0;
            wdata_q     <= '0;
            word0_q     <= '0;
            word1_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_cause_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_cause_q <= rsp_cause_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                waddr_q    <= req_addr_i[31:2];
                off_q      <= req_addr_i[1:0];
                size_q     <= req_size_i;
                cause_q    <= req_cause;
                store_q    <= req_store_i;
                unsigned_q <= req_unsigned_i;
                cross_q    <= req_cross;
                wdata_q    <= req_wdata_i;
            end
            if (state_q == StAcc0 && !store_q) word0_q <= mem_rdata_i;
            if (state_q == StAcc1 && !store_q) word1_q <= mem_rdata_i;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_fault_o = rsp_fault_q;
    assign rsp_cause_o = rsp_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a byte-array data memory model.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_fault, mem_read;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  rsp_cause, mem_load_type;
    logic [3:0]  mem_wr_en;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .MEM_BYTES(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_store_i(req_store), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_fault_o(rsp_fault),
        .rsp_cause_o(rsp_cause),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_en_o(mem_wr_en),
        .mem_read_o(mem_read), .mem_load_type_o(mem_load_type), .mem_rdata_i(mem_rdata)
    );

    // Memory model: combinational read, byte-strobed write, plus a preload port.
    logic [7:0]  mem [0:1023];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_wa = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pre_we) mem[{pre_wa, 2'(k)}] <= pre_data[8*k +: 8];
            if (mem_wr_en[k]) mem[{mem_addr[9:2], 2'(k)}] <= mem_wdata[8*k +: 8];
        end
    end

    assign mem_rdata = {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                        mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]};

    function automatic logic [31:0] rd_word(input logic [9:0] a);
        return {mem[{a[9:2], 2'd3}], mem[{a[9:2], 2'd2}], mem[{a[9:2], 2'd1}],
                mem[{a[9:2], 2'd0}]};
    endfunction

    logic [31:0] s_addr [4];
    logic [31:0] s_wdata [4];
    logic [3:0]  s_we [4];
    logic        s_rd [4];
    logic        s_ready0;

    task automatic snap(input int i);
        if (i < 4) begin
            s_addr[i] = mem_addr; s_wdata[i] = mem_wdata; s_we[i] = mem_wr_en; s_rd[i] = mem_read;
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_wa = a[9:2]; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Drives one request; returns 1 ns after the accept edge with cycle-0 snapshot taken.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic st,
                         input logic [1:0] sz, input logic us);
        req_addr = a; req_wdata = wd; req_store = st; req_size = sz; req_unsigned = us;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        snap(0);
        s_ready0 = req_ready;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            snap(i);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", req_ready); end
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        vecs++; if ({rsp_fault, rsp_cause, rsp_rdata} !== 35'd0) begin errs++;
            $display("FAIL rst_rsp got f%b c%b d%h want 0", rsp_fault, rsp_cause, rsp_rdata); end
        vecs++; if ({mem_addr, mem_wdata, mem_wr_en, mem_read} !== 69'd0) begin errs++;
            $display("FAIL rst_mem got a%h d%h we%b rd%b want 0", mem_addr, mem_wdata, mem_wr_en, mem_read); end
        vecs++; if (mem_load_type !== 2'b10) begin errs++; $display("FAIL load_type got %b want 10", mem_load_type); end
    endtask

    task automatic test_store_word();
        int lat;
        preload(10'h010, 32'h0);
        issue(32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0);
        wait_rsp(lat);
        vecs++; if (s_ready0 !== 1'b0) begin errs++; $display("FAIL sw_busy_ready got %b want 0", s_ready0); end
        vecs++; if (s_addr[0] !== 32'h10) begin errs++; $display("FAIL sw_addr got %h want 00000010", s_addr[0]); end
        vecs++; if (s_we[0] !== 4'b1111) begin errs++; $display("FAIL sw_we got %b want 1111", s_we[0]); end
        vecs++; if (s_wdata[0] !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wdata got %h want deadbeef", s_wdata[0]); end
        vecs++; if (lat != 2) begin errs++; $display("FAIL sw_latency got %0d want 2", lat); end
        vecs++; if (rsp_fault !== 1'b0) begin errs++; $display("FAIL sw_fault got %b want 0", rsp_fault); end
        vecs++; if (rd_word(10'h010) !== 32'hDEADBEEF) begin errs++;
            $display("FAIL sw_mem got %h want deadbeef", rd_word(10'h010)); end
        @(posedge clk); #1;
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL sw_pulse got %b want 0", rsp_valid); end
    endtask

    task automatic test_loads();
        logic [31:0] la [6] = '{32'h13, 32'h13, 32'h10, 32'h11, 32'h12, 32'h10};
        logic [1:0]  ls [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
        logic        lu [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] le [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234, 32'hFFFFFF12,
                                32'h000080FF, 32'h80FF1234};
        int lat;
        preload(10'h010, 32'h80FF1234);
        for (int i = 0; i < 6; i++) begin
            issue(la[i], 32'h0, 1'b0, ls[i], lu[i]);
            wait_rsp(lat);
            vecs++; if (s_rd[0] !== 1'b1 || s_addr[0] !== 32'h10 || s_we[0] !== 4'd0) begin errs++;
                $display("FAIL ld%0d_acc got rd%b a%h we%b want rd1 a00000010 we0000", i, s_rd[0], s_addr[0], s_we[0]); end
            vecs++; if (lat != 2) begin errs++; $display("FAIL ld%0d_latency got %0d want 2", i, lat); end
            vecs++; if (rsp_rdata !== le[i] || rsp_fault !== 1'b0) begin errs++;
                $display("FAIL ld%0d_data got %h f%b want %h f0", i, rsp_rdata, rsp_fault, le[i]); end
        end
    endtask

    task automatic test_cross();
        int lat;
        preload(10'h010, 32'h0);
        preload(10'h014, 32'h0);
        issue(32'h13, 32'h0000ABCD, 1'b1, 2'b01, 1'b0);
        wait_rsp(lat);
        vecs++; if (s_we[0] !== (SPLIT ? 4'b1000 : 4'b0000) || s_rd[0] !== 1'b0) begin errs++;
            $display("FAIL sh_acc0_we got %b rd%b want %b", s_we[0], s_rd[0], SPLIT ? 4'b1000 : 4'b0000); end
        vecs++; if (s_wdata[0] !== (SPLIT ? 32'hCD000000 : 32'h0)) begin errs++;
            $display("FAIL sh_acc0_wdata got %h want %h", s_wdata[0], SPLIT ? 32'hCD000000 : 32'h0); end
        vecs++; if (s_addr[1] !== (SPLIT ? 32'h14 : 32'h0) || s_we[1] !== (SPLIT ? 4'b0001 : 4'b0000)) begin errs++;
            $display("FAIL sh_acc1 got a%h we%b want split=%b", s_addr[1], s_we[1], SPLIT); end
        vecs++; if (s_wdata[1] !== (SPLIT ? 32'h000000AB : 32'h0)) begin errs++;
            $display("FAIL sh_acc1_wdata got %h want %h", s_wdata[1], SPLIT ? 32'hAB : 32'h0); end
        vecs++; if (lat != (SPLIT ? 3 : 1)) begin errs++; $display("FAIL sh_latency got %0d want %0d", lat, SPLIT ? 3 : 1); end
        vecs++; if (rsp_fault !== !SPLIT || rsp_cause !== (SPLIT ? 2'b00 : 2'b01)) begin errs++;
            $display("FAIL sh_fault got f%b c%b want split=%b", rsp_fault, rsp_cause, SPLIT); end
        vecs++; if (rd_word(10'h010) !== (SPLIT ? 32'hCD000000 : 32'h0) || rd_word(10'h014) !== (SPLIT ? 32'hAB : 32'h0)) begin errs++;
            $display("FAIL sh_mem got %h %h split=%b", rd_word(10'h010), rd_word(10'h014), SPLIT); end
        preload(10'h010, 32'h44332211);
        preload(10'h014, 32'h88776655);
        issue(32'h12, 32'h0, 1'b0, 2'b10, 1'b0);
        wait_rsp(lat);
        vecs++; if (lat != (SPLIT ? 3 : 1)) begin errs++; $display("FAIL lw_x_latency got %0d want %0d", lat, SPLIT ? 3 : 1); end
        vecs++; if (rsp_rdata !== (SPLIT ? 32'h66554433 : 32'h0)) begin errs++;
            $display("FAIL lw_x_data got %h want %h", rsp_rdata, SPLIT ? 32'h66554433 : 32'h0); end
        vecs++; if (rsp_cause !== (SPLIT ? 2'b00 : 2'b01) || s_rd[0] !== SPLIT) begin errs++;
            $display("FAIL lw_x_cause got c%b rd%b want split=%b", rsp_cause, s_rd[0], SPLIT); end
    endtask

    task automatic test_faults();
        logic [31:0] fa [4] = '{32'h3FE, 32'h400, 32'h0, 32'h7FC};
        logic [1:0]  fs [4] = '{2'b10, 2'b00, 2'b11, 2'b11};
        logic        ft [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  fc [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(fa[i], 32'hFFFFFFFF, ft[i], fs[i], 1'b0);
            wait_rsp(lat);
            vecs++; if (lat != 1) begin errs++; $display("FAIL flt%0d_latency got %0d want 1", i, lat); end
            vecs++; if (rsp_fault !== 1'b1 || rsp_cause !== fc[i] || rsp_rdata !== 32'h0) begin errs++;
                $display("FAIL flt%0d_rsp got f%b c%b d%h want f1 c%b d0", i, rsp_fault, rsp_cause, rsp_rdata, fc[i]); end
            vecs++; if (s_we[0] !== 4'd0 || s_rd[0] !== 1'b0) begin errs++;
                $display("FAIL flt%0d_mem got we%b rd%b want 0", i, s_we[0], s_rd[0]); end
        end
        preload(10'h3FC, 32'h0);
        issue(32'h3FF, 32'h0000005A, 1'b1, 2'b00, 1'b0);
        wait_rsp(lat);
        vecs++; if (lat != 2 || rsp_fault !== 1'b0) begin errs++; $display("FAIL sb_top got lat%0d f%b want lat2 f0", lat, rsp_fault); end
        vecs++; if (s_we[0] !== 4'b1000 || s_wdata[0] !== 32'h5A000000) begin errs++;
            $display("FAIL sb_top_lane got we%b d%h want 1000 5a000000", s_we[0], s_wdata[0]); end
        vecs++; if (rd_word(10'h3FC) !== 32'h5A000000) begin errs++; $display("FAIL sb_top_mem got %h want 5a000000", rd_word(10'h3FC)); end
    endtask

    task automatic test_reset_mid();
        preload(10'h020, 32'h0);
        issue(32'h20, 32'h12345678, 1'b1, 2'b10, 1'b0);
        vecs++; if (s_we[0] !== 4'b1111) begin errs++; $display("FAIL rmid_acc0 got %b want 1111", s_we[0]); end
        reset = 1'b1;
        #1;
        vecs++; if (mem_wr_en !== 4'd0 || mem_addr !== 32'd0) begin errs++;
            $display("FAIL rmid_drop got we%b a%h want 0", mem_wr_en, mem_addr); end
        @(posedge clk); #1;
        reset = 1'b0;
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got %b want 1", req_ready); end
        repeat (3) begin
            @(posedge clk); #1;
            vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rmid_no_rsp got %b want 0", rsp_valid); end
        end
        vecs++; if (rd_word(10'h020) !== 32'h0) begin errs++; $display("FAIL rmid_mem got %h want 0", rd_word(10'h020)); end
    endtask

    initial begin
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_store = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_store_word();
        test_loads();
        test_cross();
        test_faults();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
